decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 nReset  input  1  asynchronous, active-low reset.
REQ-003 opcode  input  6  instruction opcode field.
REQ-004 Bflag  input  1  branch condition flag from the ALU/flag logic (1 = condition met).
REQ-005 Ben  input  1  unconditional branch enable (1 = force branch).
REQ-006 INen  input  1  input-port enable (1 = external input data valid).
REQ-007 PCincr  output  1  1 = PC increments; 0 = PC loads branch target.
REQ-008 func  output  1  ALU function: 0 = add, 1 = multiply.
REQ-009 inp  output  1  1 = register write data sourced from the input port.
REQ-010 imm  output  1  1 = ALU operand B is the immediate field.
REQ-011 w  output  1  register-file write enable.
REQ-012 One clock; reset is asynchronous and active-low.

Function
REQ-013 The decoder SHALL decode opcode combinationally and register all five outputs on the rising clk edge (1-cycle latency).
REQ-014 The decoder SHALL decode ADD (6'b000000) as w=1, imm=0, func=0, PCincr=1, inp=INen.
REQ-015 The decoder SHALL decode ADDI (6'b000001) as w=1, imm=1, func=0, inp=0, PCincr=1.
REQ-016 The decoder SHALL decode MULI (6'b000010) as w=1, imm=1, func=1, inp=0, PCincr=1.
REQ-017 The decoder SHALL decode B (6'b000011) as w=0, imm=0, func=0, inp=0, with branch taken = Ben OR Bflag.
REQ-018 For B, a taken branch SHALL give PCincr=0 and a not-taken branch SHALL give PCincr=1.
REQ-019 Bflag and Ben SHALL affect only the B opcode and be ignored for all other opcodes.
REQ-020 INen SHALL affect only inp for the ADD opcode and be ignored for all other opcodes.
REQ-021 Any other opcode (6'b000100 to 6'b111111) SHALL decode as a NOP: w=0, imm=0, func=0, inp=0, PCincr=1.
REQ-022 An opcode containing X/Z SHALL decode as a NOP in synthesis.
REQ-023 The decoder SHALL use a default-then-override decode so no latches are inferred.
REQ-024 Input changes between clock edges SHALL NOT alter outputs until the next rising edge.

Reset
REQ-025 While nReset=0, all outputs SHALL be forced immediately, without waiting for clk, to PCincr=0, func=0, inp=0, imm=0, w=0.
REQ-026 PCincr=0 during reset holds the PC.
REQ-027 Reset assertion mid-instruction SHALL discard the pending decode.
REQ-028 The first rising clk edge after nReset deasserts SHALL register the decode of the current inputs.

Structure
REQ-029 A shared package picomips_pkg SHALL hold the opcode constants OP_ADD, OP_ADDI, OP_MULI and OP_B (6-bit each).
REQ-030 picomips_pkg SHALL hold ALU function constants ALU_ADD=0 and ALU_MUL=1.
REQ-031 The decoder SHALL be a single module, one combinational decode block plus one output register block, with no sub-modules.

Verification
REQ-032 Reset test: nReset=0 with opcode=6'b000001 -> all outputs 0 immediately, before any clk edge.
REQ-033 ADD/INen test: opcode=6'b000000, INen=0 -> after 1 clk, w=1, imm=0, func=0, inp=0, PCincr=1.
REQ-034 ADD/INen test: then INen=1 -> inp=1 at the next edge, other outputs unchanged.
REQ-035 ADDI/MULI test: opcode=6'b000001 -> w=1, imm=1, func=0.
REQ-036 ADDI/MULI test: then opcode=6'b000010 -> w=1, imm=1, func=1.
REQ-037 Branch matrix test: opcode=6'b000011 with (Ben,Bflag) = 00, 10, 01, 11 -> PCincr = 1, 0, 0, 0, and w=0 in all cases.
REQ-038 Illegal-opcode test: opcode=6'b111111 with Ben=1, Bflag=1, INen=1 -> NOP: w=0, imm=0, func=0, inp=0, PCincr=1.
REQ-039 Latency test: opcode changes mid-cycle from ADD to B with Ben=1 -> outputs keep ADD values until the next edge, then PCincr=0.

Source files
------------

// File: rtl/picomips_pkg.sv
// Shared picoMIPS constants: opcode encodings, ALU function codes and the
// packed control word the decoder registers.
package picomips_pkg;

    localparam int OPW = 6;

    localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
    localparam logic [OPW-1:0] OP_ADDI = 6'b000001;
    localparam logic [OPW-1:0] OP_MULI = 6'b000010;
    localparam logic [OPW-1:0] OP_B    = 6'b000011;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_MUL = 1'b1;

    typedef struct packed {
        logic pcincr;
        logic func;
        logic inp;
        logic imm;
        logic w;
    } ctrl_t;

    // Reset word holds the PC (pcincr=0); NOP word lets the PC advance.
    localparam ctrl_t CTRL_RESET = '{pcincr: 1'b0, func: ALU_ADD, inp: 1'b0, imm: 1'b0, w: 1'b0};
    localparam ctrl_t CTRL_NOP   = '{pcincr: 1'b1, func: ALU_ADD, inp: 1'b0, imm: 1'b0, w: 1'b0};

endpackage

// File: rtl/decoder.sv
// picoMIPS instruction decoder: combinational opcode decode feeding a single
// output register, so every control signal appears one clk after its opcode.
module decoder
    import picomips_pkg::*;
(
    input  logic           clk,
    input  logic           nReset,
    input  logic [OPW-1:0] opcode,
    input  logic           Bflag,
    input  logic           Ben,
    input  logic           INen,
    output logic           PCincr,
    output logic           func,
    output logic           inp,
    output logic           imm,
    output logic           w
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Start from NOP and override per opcode; unknown or X opcodes fall through.
    always_comb begin
        ctrl_d = CTRL_NOP;
        case (opcode)
            OP_ADD: begin
                ctrl_d.w   = 1'b1;
                ctrl_d.inp = INen;
            end
            OP_ADDI: begin
                ctrl_d.w   = 1'b1;
                ctrl_d.imm = 1'b1;
            end
            OP_MULI: begin
                ctrl_d.w    = 1'b1;
                ctrl_d.imm  = 1'b1;
                ctrl_d.func = ALU_MUL;
            end
            OP_B: begin
                ctrl_d.pcincr = ~(Ben | Bflag);
            end
            default: ctrl_d = CTRL_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            ctrl_q <= CTRL_RESET;
        else
            ctrl_q <= ctrl_d;
    end

    assign PCincr = ctrl_q.pcincr;
    assign func   = ctrl_q.func;
    assign inp    = ctrl_q.inp;
    assign imm    = ctrl_q.imm;
    assign w      = ctrl_q.w;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for the picoMIPS decoder; outputs compared as the word
// {PCincr, func, inp, imm, w} against hand-computed values.
module tb_decoder;

    logic       clk;
    logic       nReset;
    logic [5:0] opcode;
    logic       Bflag;
    logic       Ben;
    logic       INen;
    logic       PCincr;
    logic       func;
    logic       inp;
    logic       imm;
    logic       w;

    int nvec = 0;
    int nerr = 0;

    decoder dut (
        .clk    (clk),
        .nReset (nReset),
        .opcode (opcode),
        .Bflag  (Bflag),
        .Ben    (Ben),
        .INen   (INen),
        .PCincr (PCincr),
        .func   (func),
        .inp    (inp),
        .imm    (imm),
        .w      (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCincr, func, inp, imm, w}
    localparam logic [4:0] E_RST  = 5'b00000;
    localparam logic [4:0] E_ADD0 = 5'b10001;
    localparam logic [4:0] E_ADD1 = 5'b10101;
    localparam logic [4:0] E_ADDI = 5'b10011;
    localparam logic [4:0] E_MULI = 5'b11011;
    localparam logic [4:0] E_BNT  = 5'b10000;
    localparam logic [4:0] E_BT   = 5'b00000;
    localparam logic [4:0] E_NOP  = 5'b10000;

    logic [4:0] obs;
    assign obs = {PCincr, func, inp, imm, w};

    task automatic drive(input logic [5:0] op, input logic ben_i, input logic bflag_i, input logic inen_i);
        @(negedge clk);
        opcode = op;
        Ben    = ben_i;
        Bflag  = bflag_i;
        INen   = inen_i;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        opcode = 6'b000001;
        Ben = 1'b0; Bflag = 1'b0; INen = 1'b0;
        #2;
        nvec++;
        if (obs !== E_RST) begin
            nerr++;
            $display("FAIL reset_immediate: got %b expected %b", obs, E_RST);
        end
        tick();
        tick();
        nvec++;
        if (obs !== E_RST) begin
            nerr++;
            $display("FAIL reset_held: got %b expected %b", obs, E_RST);
        end
        @(negedge clk);
        nReset = 1'b1;
        tick();
        nvec++;
        if (obs !== E_ADDI) begin
            nerr++;
            $display("FAIL reset_first_edge: got %b expected %b", obs, E_ADDI);
        end
    endtask

    task automatic test_add_inen();
        drive(6'b000000, 1'b0, 1'b0, 1'b0);
        tick();
        nvec++;
        if (obs !== E_ADD0) begin
            nerr++;
            $display("FAIL add_inen0: got %b expected %b", obs, E_ADD0);
        end
        drive(6'b000000, 1'b0, 1'b0, 1'b1);
        tick();
        nvec++;
        if (obs !== E_ADD1) begin
            nerr++;
            $display("FAIL add_inen1: got %b expected %b", obs, E_ADD1);
        end
        drive(6'b000000, 1'b1, 1'b1, 1'b0);
        tick();
        nvec++;
        if (obs !== E_ADD0) begin
            nerr++;
            $display("FAIL add_branch_ignored: got %b expected %b", obs, E_ADD0);
        end
    endtask

    task automatic test_addi_muli();
        drive(6'b000001, 1'b0, 1'b0, 1'b0);
        tick();
        nvec++;
        if (obs !== E_ADDI) begin
            nerr++;
            $display("FAIL addi: got %b expected %b", obs, E_ADDI);
        end
        drive(6'b000010, 1'b0, 1'b0, 1'b0);
        tick();
        nvec++;
        if (obs !== E_MULI) begin
            nerr++;
            $display("FAIL muli: got %b expected %b", obs, E_MULI);
        end
        drive(6'b000001, 1'b1, 1'b1, 1'b1);
        tick();
        nvec++;
        if (obs !== E_ADDI) begin
            nerr++;
            $display("FAIL addi_flags_ignored: got %b expected %b", obs, E_ADDI);
        end
        drive(6'b000010, 1'b1, 1'b1, 1'b1);
        tick();
        nvec++;
        if (obs !== E_MULI) begin
            nerr++;
            $display("FAIL muli_flags_ignored: got %b expected %b", obs, E_MULI);
        end
    endtask

    task automatic test_branch();
        logic [1:0] combos [4]   = '{2'b00, 2'b10, 2'b01, 2'b11};
        logic [4:0] expect_b [4] = '{E_BNT, E_BT, E_BT, E_BT};
        for (int i = 0; i < 4; i++) begin
            drive(6'b000011, combos[i][1], combos[i][0], 1'b1);
            tick();
            nvec++;
            if (obs !== expect_b[i]) begin
                nerr++;
                $display("FAIL branch_ben%b_bflag%b: got %b expected %b",
                         combos[i][1], combos[i][0], obs, expect_b[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [3] = '{6'b111111, 6'b000100, 6'b100000};
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], 1'b1, 1'b1, 1'b1);
            tick();
            nvec++;
            if (obs !== E_NOP) begin
                nerr++;
                $display("FAIL illegal_%b: got %b expected %b", ops[i], obs, E_NOP);
            end
        end
    endtask

    task automatic test_latency();
        drive(6'b000000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(6'b000011, 1'b1, 1'b0, 1'b0);
        #1;
        nvec++;
        if (obs !== E_ADD0) begin
            nerr++;
            $display("FAIL latency_hold: got %b expected %b", obs, E_ADD0);
        end
        tick();
        nvec++;
        if (obs !== E_BT) begin
            nerr++;
            $display("FAIL latency_update: got %b expected %b", obs, E_BT);
        end
    endtask

    task automatic test_reset_mid();
        drive(6'b000010, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        nReset = 1'b0;
        #1;
        nvec++;
        if (obs !== E_RST) begin
            nerr++;
            $display("FAIL reset_mid_async: got %b expected %b", obs, E_RST);
        end
        tick();
        nvec++;
        if (obs !== E_RST) begin
            nerr++;
            $display("FAIL reset_mid_discard: got %b expected %b", obs, E_RST);
        end
        @(negedge clk);
        opcode = 6'b000000;
        INen   = 1'b1;
        nReset = 1'b1;
        tick();
        nvec++;
        if (obs !== E_ADD1) begin
            nerr++;
            $display("FAIL reset_mid_resume: got %b expected %b", obs, E_ADD1);
        end
    endtask

    initial begin
        test_reset();
        test_add_inen();
        test_addi_muli();
        test_branch();
        test_illegal();
        test_latency();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
